if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline latch.
- A DEPTH-entry in-order FIFO between fetch and decode. Each entry holds {npc, instr} plus a valid bit.
- Fetch keeps pushing on ihit while decode is stalled, so short decode stalls do not throttle fetch.
- Supports squash (flush) on branch/jump resolution; output presents a NOP bubble when empty.

Parameters:
- WIDTH, 32, bit width of the npc and instr fields.
- DEPTH, 4, number of entries; power of two, >= 2.
- NOP_WORD, 32'h0, instr value driven on instr_out when the queue is empty.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  asynchronous active-low reset.
- npc_in  input  WIDTH  next-PC from fetch.
- imemload  input  WIDTH  fetched instruction word.
- ihit  input  1  fetch word valid this cycle (push request).
- stall  input  1  decode cannot accept the head entry this cycle.
- flush  input  1  squash all queued entries (branch/jump taken).
- npc_out  output  WIDTH  npc of head entry.
- instr_out  output  WIDTH  instruction of head entry.
- valid_out  output  1  head entry valid.
- ready  output  1  queue can accept a push (not full).
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (nRST low, asynchronous):
  - Pointers and count go to 0 and all storage is cleared.
  - Outputs: valid_out=0, npc_out=0, instr_out=NOP_WORD, ready=1, count=0.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Storage: DEPTH x (2*WIDTH) register array with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. count is held as a register, not derived from the pointers.
- Outputs are combinational from registered state only; no combinational path from any input to any output.
  - When count>0: npc_out=mem[rd_ptr].npc, instr_out=mem[rd_ptr].instr, valid_out=1.
  - When count==0: npc_out=0, instr_out=NOP_WORD, valid_out=0.
- ready = (count != DEPTH). full = !ready.
- pop = valid_out && !stall && !flush.
- push = ihit && ready && !flush.
  - Push is decided on pre-edge ready. A push while full is dropped even if a pop occurs in the same cycle; fetch must hold PC while ready=0.
- Latency: a word pushed into an empty queue appears on the outputs in the cycle after the push edge (1-cycle latency, same as the old latch).
- Simultaneous push and pop with 0<count<DEPTH: both happen and count is unchanged.
- Empty with stall=0: no pop; the bubble persists.
- Flush has the highest priority:
  - On a flush edge: rd_ptr=wr_ptr=0, count=0, valid_out=0 next cycle.
  - An ihit in the flush cycle is discarded.
  - Stale storage contents need not be cleared.
- stall with valid_out=1: head entry and outputs hold exactly.
- Pointer wrap: wr_ptr DEPTH-1 -> 0 and rd_ptr DEPTH-1 -> 0 with no loss of order.
- Invariants for the checker: 0 <= count <= DEPTH; FIFO order preserved; never more than one push and one pop per cycle.

Optional Feature:
- Macro: IFID_QUEUE_PERF_EN.
- When defined, add three output ports:
  - stall_cycles [31:0]: increments each cycle valid_out && stall.
  - bubble_cycles [31:0]: increments each cycle !valid_out && !stall.
  - flush_count [15:0]: increments per flush cycle.
- All three counters reset to 0 on nRST and saturate at all-ones.
- When not defined, the three ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle, no ihit -> valid_out=0, instr_out=32'h0, ready=1, count=0 for 10 cycles.
- Stream push, stall=0: ihit 3 cycles with (npc,instr) = (4,A), (8,B), (C,C) -> outputs (4,A), (8,B), (C,C) on the next 3 cycles in order, count stays 1.
- Fill to full under stall=1: 5 ihits with DEPTH=4 -> count=4, ready=0 after the 4th; 5th word dropped. Release stall -> first 4 words drain in order, then valid_out=0.
- Wrap-around: push/pop 10 words interleaved with random 1-cycle stalls -> every word seen exactly once, in order, across pointer wrap.
- Flush with count=3 and simultaneous ihit -> next cycle valid_out=0, count=0. Following ihit (npc=0x40) appears alone as the next head.
- Async reset pulse mid-cycle with count=2 -> outputs return to reset values before the next CLK edge. With IFID_QUEUE_PERF_EN defined, all counters read 0.

Source files
------------

// File: rtl/if_id_queue.sv
// In-order fetch/decode queue: DEPTH entries of {npc, instr}, squash on flush, NOP bubble when empty.
// Optional performance counters are enabled with `define IFID_QUEUE_PERF_EN.
module if_id_queue #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [WIDTH-1:0]         npc_in,
  input  logic [WIDTH-1:0]         imemload,
  input  logic                     ihit,
  input  logic                     stall,
  input  logic                     flush,
  output logic [WIDTH-1:0]         npc_out,
  output logic [WIDTH-1:0]         instr_out,
  output logic                     valid_out,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef IFID_QUEUE_PERF_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              bubble_cycles,
  output logic [15:0]              flush_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_npc   [DEPTH];
  logic [WIDTH-1:0] mem_instr [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push;
  logic             pop;

  // Head presentation depends only on registered state.
  assign valid_out = (count != CW'(0));
  assign ready     = (count != CW'(DEPTH));
  assign npc_out   = valid_out ? mem_npc[rd_ptr]   : '0;
  assign instr_out = valid_out ? mem_instr[rd_ptr] : NOP_WORD;

  // A push while full is dropped even if the head pops in the same cycle.
  assign pop  = valid_out && !stall && !flush;
  assign push = ihit && ready && !flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_npc[i]   <= '0;
        mem_instr[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_npc[wr_ptr]   <= npc_in;
        mem_instr[wr_ptr] <= imemload;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef IFID_QUEUE_PERF_EN
  // Saturating activity counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
      flush_count   <= '0;
    end else begin
      if (valid_out && stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'(1);
      end
      if (!valid_out && !stall && (bubble_cycles != '1)) begin
        bubble_cycles <= bubble_cycles + 32'(1);
      end
      if (flush && (flush_count != '1)) begin
        flush_count <= flush_count + 16'(1);
      end
    end
  end
`endif

endmodule
